// File: rtl/dht11_sensor_emu.sv
`timescale 1ns/1ps
// DHT11 responder: detects a host start pulse, returns the ACK preamble and a 40-bit frame.
// Optional CSUM_ERR_INJ_EN adds inject_bad_csum, which flips checksum bit 0 of the frame.
module dht11_sensor_emu #(
  parameter int unsigned START_MIN_US = 18000,
  parameter int unsigned RESP_WAIT_US = 30,
  parameter int unsigned ACK_US       = 80,
  parameter int unsigned BIT_LOW_US   = 50,
  parameter int unsigned BIT0_HIGH_US = 26,
  parameter int unsigned BIT1_HIGH_US = 70,
  parameter int unsigned HOLDOFF_US   = 2000
) (
  input  logic       clk1mhz,
  input  logic       rst,
  inout  wire        dht11_dat,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic       err_contention,
  output logic [3:0] status
`ifdef CSUM_ERR_INJ_EN
  ,
  input  logic       inject_bad_csum
`endif
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_MEAS  = 4'd1,
    ST_RWAIT = 4'd2,
    ST_ACKL  = 4'd3,
    ST_ACKH  = 4'd4,
    ST_BITL  = 4'd5,
    ST_BITH  = 4'd6,
    ST_ENDL  = 4'd7,
    ST_HOLD  = 4'd8
  } state_t;

  // A host release reaches the FSM three edges after the pin moves; RWAIT absorbs that
  // so the ACK low starts RESP_WAIT_US after the release as seen on the wire.
  localparam int unsigned RELEASE_LAT = 3;
  localparam logic [15:0] START_MIN   = 16'(START_MIN_US);
  localparam logic [15:0] RWAIT_LAST  = 16'(RESP_WAIT_US - RELEASE_LAT - 1);
  localparam logic [15:0] ACK_LAST    = 16'(ACK_US - 1);
  localparam logic [15:0] BITL_LAST   = 16'(BIT_LOW_US - 1);
  localparam logic [15:0] BIT0_LAST   = 16'(BIT0_HIGH_US - 1);
  localparam logic [15:0] BIT1_LAST   = 16'(BIT1_HIGH_US - 1);
  localparam logic [15:0] HOLD_LAST   = 16'(HOLDOFF_US - 1);
  localparam logic [15:0] SETTLE      = 16'd3;

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [5:0]  idx_reg, idx_next;
  logic [39:0] shift_reg, shift_next;
  logic        drive_low_reg, drive_low_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        sync1_reg, bus_s;
  logic [7:0]  csum, csum_tx;
  logic [15:0] bith_last;
  logic [15:0] cnt_inc;

  assign csum = hum_int + hum_dec + temp_int + temp_dec;
`ifdef CSUM_ERR_INJ_EN
  assign csum_tx = csum ^ {7'd0, inject_bad_csum};
`else
  assign csum_tx = csum;
`endif

  assign bith_last = shift_reg[39] ? BIT1_LAST : BIT0_LAST;
  assign cnt_inc   = cnt_reg + 16'd1;

  assign dht11_dat      = drive_low_reg ? 1'b0 : 1'bz;
  assign busy           = busy_reg;
  assign frame_done     = done_reg;
  assign err_contention = err_reg;
  assign status         = state_reg;

  // Idle bus level is high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk1mhz) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      bus_s     <= 1'b1;
    end else begin
      sync1_reg <= dht11_dat;
      bus_s     <= sync1_reg;
    end
  end

  always_ff @(posedge clk1mhz) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      drive_low_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      drive_low_reg <= drive_low_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_inc;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    drive_low_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!bus_s) begin
          state_next = ST_MEAS;
          cnt_next   = 16'd1;
        end
      end
      ST_MEAS: begin
        if (bus_s) begin
          cnt_next = '0;
          if (cnt_reg >= START_MIN) begin
            state_next = ST_RWAIT;
            busy_next  = 1'b1;
            shift_next = {hum_int, hum_dec, temp_int, temp_dec, csum_tx};
          end else begin
            state_next = ST_IDLE;
          end
        end else if (cnt_reg == 16'hFFFF) begin
          cnt_next = cnt_reg;
        end
      end
      ST_RWAIT: begin
        if (cnt_reg == RWAIT_LAST) begin
          state_next = ST_ACKL;
          cnt_next   = '0;
        end
      end
      ST_ACKL: begin
        if (cnt_reg == ACK_LAST) begin
          state_next = ST_ACKH;
          cnt_next   = '0;
        end
      end
      ST_ACKH: begin
        if (cnt_reg >= SETTLE && !bus_s) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else if (cnt_reg == ACK_LAST) begin
          state_next = ST_BITL;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      ST_BITL: begin
        if (cnt_reg == BITL_LAST) begin
          state_next = ST_BITH;
          cnt_next   = '0;
        end
      end
      ST_BITH: begin
        if (cnt_reg >= SETTLE && !bus_s) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else if (cnt_reg == bith_last) begin
          cnt_next = '0;
          if (idx_reg < 6'd39) begin
            state_next = ST_BITL;
            shift_next = {shift_reg[38:0], 1'b0};
            idx_next   = idx_reg + 6'd1;
          end else begin
            state_next = ST_ENDL;
          end
        end
      end
      ST_ENDL: begin
        if (cnt_reg == BITL_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
          done_next  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
    drive_low_next = (state_next == ST_ACKL) || (state_next == ST_BITL) ||
                     (state_next == ST_ENDL);
  end

endmodule

// File: tb/tb_dht11_sensor_emu.sv
`timescale 1ns/1ps
// Bench for dht11_sensor_emu: plays the host, decodes the frame by pulse width.
// The start threshold is scaled to 1800 us so the run stays short; other timings are nominal.
module tb_dht11_sensor_emu;
  localparam int START_MIN = 1800;
  localparam int NV = 7;
`ifdef CSUM_ERR_INJ_EN
  localparam logic [7:0] INJ_CSUM = 8'h4E;
`else
  localparam logic [7:0] INJ_CSUM = 8'h4F;
`endif

  typedef struct {
    logic [7:0] hi;
    logic [7:0] hd;
    logic [7:0] ti;
    logic [7:0] td;
    logic       inj;
    int         low_len;
    logic       accept;
    logic [7:0] csum;
  } vec_t;

  logic       clk1mhz = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  wire        dht11_dat;
  logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
  logic       busy, frame_done, err_contention;
  logic [3:0] status;
`ifdef CSUM_ERR_INJ_EN
  logic       inject_bad_csum = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  vec_t vecs[NV];

  assign dht11_dat = host_low ? 1'b0 : 1'bz;
  pullup (dht11_dat);

  always #500 clk1mhz = ~clk1mhz;

  always @(negedge clk1mhz) begin
    if (frame_done) done_cnt++;
    if (err_contention) err_cnt++;
  end

  dht11_sensor_emu #(.START_MIN_US(START_MIN)) dut (
    .clk1mhz        (clk1mhz),
    .rst            (rst),
    .dht11_dat      (dht11_dat),
    .hum_int        (hum_int),
    .hum_dec        (hum_dec),
    .temp_int       (temp_int),
    .temp_dec       (temp_dec),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_contention (err_contention),
    .status         (status)
`ifdef CSUM_ERR_INJ_EN
    ,
    .inject_bad_csum(inject_bad_csum)
`endif
  );

  initial begin
    #(120_000_000);
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic host_start(input int len);
    @(posedge clk1mhz);
    #1 host_low = 1'b1;
    repeat (len) @(posedge clk1mhz);
    #1 host_low = 1'b0;
  endtask

  task automatic wait_low(input int limit, output int n);
    n = 0;
    @(negedge clk1mhz);
    while (dht11_dat !== 1'b0 && n < limit) begin
      n++;
      @(negedge clk1mhz);
    end
  endtask

  task automatic measure(input logic lvl, input int limit, output int n);
    n = 0;
    while (dht11_dat === lvl && n < limit) begin
      n++;
      @(negedge clk1mhz);
    end
  endtask

  task automatic measure_busy(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      n++;
      @(negedge clk1mhz);
    end
  endtask

  // Runs one start + frame decode; jam_bit >= 0 pulls the bus low in that bit's high phase.
  task automatic run_frame(input int low_len, input int jam_bit, output logic [39:0] rx,
                           output int bad_w, output int dly, output int ackl,
                           output int ackh, output int endl);
    int w;
    rx = '0;
    bad_w = 0;
    endl = 0;
    ackh = 0;
    host_start(low_len);
    wait_low(200, dly);
    hum_int  = ~hum_int;
    hum_dec  = ~hum_dec;
    temp_int = ~temp_int;
    temp_dec = ~temp_dec;
`ifdef CSUM_ERR_INJ_EN
    inject_bad_csum = ~inject_bad_csum;
`endif
    measure(1'b0, 200, ackl);
    measure(1'b1, 200, ackh);
    for (int b = 0; b < 40; b++) begin
      measure(1'b0, 200, w);
      if (w != 50) bad_w++;
      if (b == jam_bit) begin
        repeat (10) @(negedge clk1mhz);
        host_low = 1'b1;
        repeat (5) @(negedge clk1mhz);
        host_low = 1'b0;
        @(negedge clk1mhz);
        return;
      end
      measure(1'b1, 200, w);
      if (w == 70) rx = {rx[38:0], 1'b1};
      else if (w == 26) rx = {rx[38:0], 1'b0};
      else begin
        bad_w++;
        rx = {rx[38:0], 1'b0};
      end
    end
    measure(1'b0, 200, endl);
  endtask

  initial begin
    logic [39:0] rx;
    int bw, dly, al, ah, el, n, lows, bz, d0, e0;

    vecs[0] = '{8'h37, 8'h00, 8'h18, 8'h00, 1'b0, START_MIN,     1'b1, 8'h4F};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, START_MIN+700, 1'b1, 8'hFC};
    vecs[2] = '{8'h37, 8'h00, 8'h18, 8'h00, 1'b0, 1000,          1'b0, 8'h00};
    vecs[3] = '{8'h37, 8'h00, 8'h18, 8'h00, 1'b0, START_MIN-1,   1'b0, 8'h00};
    vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 1'b0, START_MIN,     1'b1, 8'h14};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0, START_MIN,     1'b1, 8'h00};
    vecs[6] = '{8'h37, 8'h00, 8'h18, 8'h00, 1'b1, START_MIN,     1'b1, INJ_CSUM};

    repeat (5) @(posedge clk1mhz);
    @(negedge clk1mhz);
    check("reset_status", status, 0);
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_err", err_contention, 0);
    check("reset_bus", dht11_dat, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk1mhz);

    for (int i = 0; i < NV; i++) begin
      hum_int  = vecs[i].hi;
      hum_dec  = vecs[i].hd;
      temp_int = vecs[i].ti;
      temp_dec = vecs[i].td;
`ifdef CSUM_ERR_INJ_EN
      inject_bad_csum = vecs[i].inj;
`endif
      d0 = done_cnt;
      e0 = err_cnt;
      rx = '0;
      if (vecs[i].accept) begin
        run_frame(vecs[i].low_len, -1, rx, bw, dly, al, ah, el);
        check("ack_delay", dly, 30);
        check("ack_low", al, 80);
        check("ack_high", ah, 80);
        check("bit_widths_bad", bw, 0);
        check("end_low", el, 50);
        check("data_bytes", rx[39:8], {vecs[i].hi, vecs[i].hd, vecs[i].ti, vecs[i].td});
        check("csum", rx[7:0], vecs[i].csum);
        check("status_hold", status, 8);
        measure_busy(2100, n);
        check("holdoff", n, 2000);
        check("status_idle", status, 0);
      end else begin
        host_start(vecs[i].low_len);
        lows = 0;
        bz = 0;
        repeat (300) begin
          @(negedge clk1mhz);
          if (dht11_dat === 1'b0) lows++;
          if (busy === 1'b1) bz++;
        end
        check("reject_bus_low", lows, 0);
        check("reject_busy", bz, 0);
        check("reject_status", status, 0);
      end
      check("frame_done_count", done_cnt - d0, vecs[i].accept ? 1 : 0);
      check("err_count", err_cnt - e0, 0);
      $display("[TB] vec %0d: low=%0d inj=%0b accept=%0b rx=%010h", i, vecs[i].low_len,
               vecs[i].inj, vecs[i].accept, rx);
    end

    // Contention during the high phase of bit 12.
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h18; temp_dec = 8'h00;
`ifdef CSUM_ERR_INJ_EN
    inject_bad_csum = 1'b0;
`endif
    d0 = done_cnt;
    e0 = err_cnt;
    run_frame(START_MIN, 12, rx, bw, dly, al, ah, el);
    check("jam_err_count", err_cnt - e0, 1);
    check("jam_status", status, 8);
    check("jam_busy", busy, 1);
    lows = 0;
    repeat (50) begin
      @(negedge clk1mhz);
      if (dht11_dat === 1'b0) lows++;
    end
    check("jam_bus_released", lows, 0);
    measure_busy(2100, n);
    check("jam_status_idle", status, 0);
    check("jam_no_frame_done", done_cnt - d0, 0);
    $display("[TB] contention: err=%0d done=%0d holdoff_left=%0d", err_cnt - e0, done_cnt - d0, n);

    // Reset while the ACK low is being driven, then a normal start.
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h18; temp_dec = 8'h00;
    host_start(START_MIN);
    wait_low(200, dly);
    repeat (20) @(negedge clk1mhz);
    rst = 1'b1;
    @(negedge clk1mhz);
    check("rst_bus_released", dht11_dat, 1);
    check("rst_status", status, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk1mhz);
    hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h18; temp_dec = 8'h00;
    d0 = done_cnt;
    run_frame(START_MIN, -1, rx, bw, dly, al, ah, el);
    check("rst_restart_delay", dly, 30);
    check("rst_restart_frame", rx[39:8], 32'h37001800);
    check("rst_restart_csum", rx[7:0], 8'h4F);
    check("rst_restart_widths", bw, 0);
    $display("[TB] reset mid-ACK then restart: rx=%010h", rx);

    // A start issued during HOLD is ignored.
    host_start(START_MIN);
    check("hold_status_after_start", status, 8);
    lows = 0;
    repeat (400) begin
      @(negedge clk1mhz);
      if (dht11_dat === 1'b0) lows++;
    end
    check("hold_start_ignored", lows, 0);
    check("hold_status_idle", status, 0);
    check("hold_busy_clear", busy, 0);
    check("hold_done_count", done_cnt - d0, 1);
    $display("[TB] start during HOLD: bus_low_cycles=%0d status=%0d", lows, status);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dht11_sensor_emu.md
Name: dht11_sensor_emu

Overview:
Single-wire DHT11 sensor emulator: the responder end of the DHT11 protocol. It detects a host start pulse on the open-drain bus, returns the ACK preamble, and serialises a 40-bit frame (humidity, temperature, checksum) with DHT11 bit timing. It runs on the 1 MHz system clock (1 cycle = 1 us) and serves as an on-board stand-in and bench partner for the team's DHT11 host driver.

Parameters:
START_MIN_US, 18000, minimum host low time accepted as a start; shorter lows are rejected as glitches.
RESP_WAIT_US, 30, delay after host release before the ACK low begins.
ACK_US, 80, width of the ACK low phase and of the ACK high phase.
BIT_LOW_US, 50, low preamble before every data bit and the end-of-frame low.
BIT0_HIGH_US, 26, released-high width for a 0 bit.
BIT1_HIGH_US, 70, released-high width for a 1 bit.
HOLDOFF_US, 2000, dead time after a frame or abort during which the bus is ignored.

Ports:
clk1mhz  in  1  1 MHz clock.
rst  in  1  reset; synchronous, active-high.
dht11_dat  inout  1  open-drain bus; the block drives 0 or Z only, never 1.
hum_int  in  8  humidity integer byte.
hum_dec  in  8  humidity decimal byte.
temp_int  in  8  temperature integer byte.
temp_dec  in  8  temperature decimal byte.
busy  out  1  high from start acceptance until HOLDOFF ends.
frame_done  out  1  one-cycle pulse when the end-of-frame low completes.
err_contention  out  1  one-cycle pulse when the bus is seen low during a released phase.
status  out  4  current state code.

Behaviour:
- Input path: dht11_dat goes through a 2-flop synchroniser (bus_s). All decisions use bus_s. Latency is 2 cycles.
- Output path: drive_low reg; dht11_dat = drive_low ? 0 : Z.
- Reset values: drive_low=0, busy=0, frame_done=0, err_contention=0, status=0 (IDLE), counters=0, shift reg=0.
- Reset mid-frame releases the bus on the next edge.
- State codes and transitions:
  - IDLE(0): bus_s==0 -> MEAS(1) with cnt=1.
  - MEAS(1): cnt increments and saturates at 16 bits.
    - bus_s==1 and cnt>=START_MIN_US -> RWAIT(2); busy=1; latch shift reg.
    - bus_s==1 and cnt<START_MIN_US -> IDLE; no response.
    - A held-low bus never times out.
  - Latched frame, MSB first: {hum_int, hum_dec, temp_int, temp_dec, csum}. csum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, 8-bit wrap. Inputs are sampled only at latch; later changes do not affect the frame in flight.
  - RWAIT(2): released, RESP_WAIT_US cycles -> ACKL(3).
  - ACKL(3): drive_low=1, ACK_US cycles -> ACKH(4).
  - ACKH(4): released, ACK_US cycles -> BITL(5); bit index=0.
  - BITL(5): drive_low=1, BIT_LOW_US cycles -> BITH(6).
  - BITH(6): released; width is BIT1_HIGH_US if the current bit is 1, else BIT0_HIGH_US.
    - At end: index<39 -> shift, index+1, BITL.
    - At end: index==39 -> ENDL(7).
  - ENDL(7): drive_low=1, BIT_LOW_US cycles; on exit frame_done pulses and the state goes to HOLD(8) with the bus released.
  - HOLD(8): bus ignored for HOLDOFF_US cycles -> IDLE; busy=0 on that transition.
- Contention check (ACKH, BITH only): after the first 3 cycles of the phase (synchroniser settle), bus_s==0 -> err_contention pulse, release the bus, go to HOLD. frame_done does not pulse.
- Phase widths are exact: each phase lasts N clk1mhz cycles measured at the bus pin. Total frame from host release to end of ENDL = 30 + 160 + 40*50 + sum(highs) + 50 us.
- status mirrors the state register with no delay.

Optional Feature:
CSUM_ERR_INJ_EN:
- Defined: adds input port inject_bad_csum (1 bit), sampled at latch. When high, the transmitted checksum is csum ^ 8'h01; the data bytes are unchanged.
- Undefined: the port is absent and the checksum is always correct.

Test Plan:
- hum=55.0, temp=24.0 (0x37,0x00,0x18,0x00), host low 18 ms then release -> ACK low 80 us at +30 us; bytes 0x37 0x00 0x18 0x00 0x4F decoded by width (26 vs 70 us); frame_done pulses once; busy clears 2000 us later.
- Host low 10000 us then release -> no bus activity, busy stays 0, state returns to IDLE.
- Bytes 0xFF,0xFF,0xFF,0xFF -> csum 0xFC (wraps); all 32 data bits high for 70 us.
- Bench pulls the bus low mid-BITH of bit 12 -> err_contention one pulse, bus released, no frame_done, IDLE after HOLDOFF.
- rst asserted during ACKL -> bus released next edge, status=0; a new 18 ms start is then answered normally.
- Start pulse issued during HOLD -> ignored; with CSUM_ERR_INJ_EN and inject_bad_csum=1, 55.0/24.0 frame sends csum 0x4E.
